// File: rtl/ex_iter_shifter_if.sv
// Request/response bundle between EX control decode and the iterative shifter.
// The master drives the request side; the slave is the shifter.
interface ex_iter_shifter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic [CNT_W-1:0] count;
    logic [2:0]       dest;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [2:0]       wb_dest;

    modport master (
        output start, op, operand, count, dest,
        input  busy, stall, done, result, carry, wb_dest
    );

    modport slave (
        input  start, op, operand, count, dest,
        output busy, stall, done, result, carry, wb_dest
    );
endinterface

// File: rtl/ex_iter_shifter.sv
// EX-stage iterative shift/rotate unit: one bit position per clock, stalls IF/ID and ID/EX while busy.
// Optional macro EX_SHIFT_ASR_EN turns op 100 into an arithmetic shift right (otherwise it runs as SHR).
module ex_iter_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    ex_iter_shifter_if.slave bus
);
    localparam int NW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [NW-1:0]    cnt;
    logic [WIDTH-1:0] sh_q;
    logic             carry_q;
    logic             done_q;
    logic [2:0]       dest_q;

    logic             accept;
    logic [NW-1:0]    n_eff;
    logic [WIDTH:0]   step;

    // Rotates wrap modulo WIDTH; shifts saturate at WIDTH since further steps change nothing.
    function automatic logic [NW-1:0] eff_count(input logic [2:0] o, input logic [CNT_W-1:0] c);
        logic [31:0] c32;
        c32 = 32'(c);
        if (o == 3'b010 || o == 3'b011)
            return NW'(c32 % 32'(WIDTH));
        if (c32 >= 32'(WIDTH))
            return NW'(WIDTH);
        return NW'(c32);
    endfunction

    // One iteration: returns {bit leaving the word, next value}.
    function automatic logic [WIDTH:0] shift_step(input logic [2:0] o, input logic [WIDTH-1:0] v);
        case (o)
            3'b000:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            3'b010:  return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            3'b011:  return {v[0], v[0], v[WIDTH-1:1]};
`ifdef EX_SHIFT_ASR_EN
            3'b100:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
`endif
            default: return {v[0], 1'b0, v[WIDTH-1:1]};
        endcase
    endfunction

    // rst gating keeps stall/busy low while reset is held even if start is high.
    assign accept = bus.start && (state != SHIFT) && !rst;
    assign n_eff  = eff_count(bus.op, bus.count);
    assign step   = shift_step(op_q, sh_q);

    assign bus.stall   = accept || (state == SHIFT);
    assign bus.busy    = (state == SHIFT) || (accept && (n_eff != '0));
    assign bus.done    = done_q;
    assign bus.result  = sh_q;
    assign bus.carry   = carry_q;
    assign bus.wb_dest = dest_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            cnt     <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            dest_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                SHIFT: begin
                    sh_q    <= step[WIDTH-1:0];
                    carry_q <= step[WIDTH];
                    cnt     <= cnt - NW'(1);
                    if (cnt == NW'(1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                    if (accept) begin
                        sh_q    <= bus.operand;
                        op_q    <= bus.op;
                        dest_q  <= bus.dest;
                        carry_q <= 1'b0;
                        cnt     <= n_eff;
                        if (n_eff == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/ex_iter_shifter.md
Name: ex_iter_shifter

Overview:
- EX-stage consumer of the ID/EX pipeline-register outputs (control, read1, shift_count, destination field).
- Executes shift and rotate operations iteratively, one bit position per clock.
- Raises a stall toward the hazard logic so that IF/ID and ID/EX hold while a shift is in flight.
- Delivers the result, carry and destination register to the EX/MEM path with a one-cycle done pulse.

Parameters:
- WIDTH, 8, datapath width in bits. Also the maximum number of iterations per operation.
- CNT_W, 8, width of the shift-count input. Matches the 8-bit shift_count field.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request from EX control decode; operands are valid in the same cycle
- op  in  3  000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 ASR (see Optional Feature), 101-111 reserved
- operand  in  WIDTH  value to shift (EX_read1)
- count  in  CNT_W  requested shift amount (EX_shift_count)
- dest  in  3  destination register index (EX_inst13_11)
- busy  out  1  high while an operation is in flight
- stall  out  1  pipeline hold request (combinational)
- done  out  1  one-cycle pulse; result, carry and wb_dest are valid in this cycle
- result  out  WIDTH  shifted value
- carry  out  1  last bit shifted or rotated out
- wb_dest  out  3  captured dest

Behaviour:
- Reset:
  - rst asserted at any time forces state IDLE immediately.
  - busy=0, done=0, result=0, carry=0, wb_dest=0, internal counter=0.
  - stall=0 while rst is high.
- States: IDLE, SHIFT, DONE.
- Start acceptance:
  - start is sampled only in IDLE or DONE; it is ignored in SHIFT.
  - On acceptance, the block captures operand into the shift register, op, dest, and the effective count n.
  - Carry is cleared on acceptance.
- Effective count n:
  - Rotates: n = count mod WIDTH.
  - Shifts: n = min(count, WIDTH).
- Transitions on acceptance:
  - n>0: go to SHIFT.
  - n=0: go straight to DONE with result=operand and carry=0.
- SHIFT:
  - One bit position per cycle; carry takes the bit leaving the word.
  - SHL fills 0 at the LSB. SHR fills 0 at the MSB.
  - ROL and ROR wrap the departing bit into the vacated position.
  - The counter decrements each cycle; when it reaches 0, go to DONE.
- DONE (exactly one cycle):
  - done=1; result, carry and wb_dest are presented.
  - Next state: SHIFT or DONE if a new start is accepted, otherwise IDLE.
- Output hold: result, carry and wb_dest hold their values after DONE until the next acceptance or reset.
- Latency: acceptance at cycle T gives done at cycle T+n+1.
- busy = state is SHIFT, or start accepted with n>0 in the current cycle.
- stall:
  - stall = (start accepted in this cycle) OR (state==SHIFT).
  - stall is low in the DONE cycle so the pipeline advances with the result.
  - Consequence: an n=0 accepted request still stalls for exactly one cycle.
- Reserved ops: execute as SHR.
- Simultaneous rst and start: rst wins; the start is discarded.
- Back-to-back: start in the DONE cycle is accepted; the next op's stall begins in that same cycle.

Optional Feature:
- Macro: EX_SHIFT_ASR_EN.
- Defined: op 100 is an arithmetic shift right. The MSB is replicated on each iteration; carry is the bit leaving the LSB. n saturates at WIDTH, so the result is all copies of the sign bit.
- Undefined: op 100 is treated as reserved and executes as SHR. No sign-replication logic is present.

Test Plan:
- SHL, operand 0x81, count 1 at cycle T -> stall=1 at T and T+1, done at T+2, result 0x02, carry 1, wb_dest=dest.
- ROR, operand 0x01, count 9 -> n=1, done at T+2, result 0x80, carry 1. ROL, operand 0xA5, count 8 -> n=0, done at T+1, result 0xA5, carry 0.
- SHR, operand 0xF0, count 12 -> saturates to 8 iterations, done at T+9, result 0x00, carry 1. busy high T..T+8.
- ASR, operand 0x80, count 3 -> with EX_SHIFT_ASR_EN: result 0xF0, carry 0. Without it: result 0x10, carry 0.
- Reset mid-op: SHL 0xFF by 6, assert rst at T+3 (asynchronously, mid-cycle) -> busy, stall, done, result and carry are 0 immediately. After release, no done pulse occurs; a new SHL 0x01 by 2 gives 0x04 at T'+3.
- Back-to-back: start in the DONE cycle with SHR 0x08 by 3 -> first done pulse intact, second done 4 cycles later, result 0x01, carry 0. start pulsed during SHIFT is ignored.
